mem_seq_ctrl: RTL
=================

# mem_seq_ctrl

Sequencer for the board-level memory datapath: copies a block of words from the combinational instruction ROM into the single-port data RAM, optionally reads the block back and checks it, then owns the RAM port for a display scan that walks the block word by word for the 8-channel display multiplexer. It sits between the debounced switch/button/clock-divider outputs and the ROM/RAM, replacing ad-hoc address wiring. It is the only master of the RAM port.

## Interface
Parameters:
- ADDR_W, 10, RAM/ROM word-address width
- DATA_W, 32, word width

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a copy of len words starting at base
- scan_tick  in  1  one-cycle pulse; advances the display scan address
- base  in  ADDR_W  first word address (applies to both ROM and RAM)
- len  in  ADDR_W  number of words to copy; 0 means no-op
- rom_a  out  ADDR_W  ROM address
- rom_d  in  DATA_W  ROM data, combinational from rom_a
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one clk after ram_addr is presented
- disp_data  out  DATA_W  word currently shown on the display channel
- disp_addr  out  ADDR_W  address of disp_data
- busy  out  1  high in COPY and VERIFY
- done  out  1  one-cycle pulse when a sequence completes
- err  out  1  sticky verify mismatch flag, cleared by the next start

## Operation
- States: IDLE, COPY, VERIFY, SCAN.
- Reset: state=IDLE. All outputs are 0: rom_a, ram_addr, ram_we, ram_din, disp_data, disp_addr, busy, done and err. The internal counter idx is 0.
- IDLE/SCAN + start, len=0: stay in (or enter) SCAN. Pulse done the next cycle. Do not write.
- IDLE/SCAN + start, len>0: idx<=0, err<=0, go to COPY.
- COPY: rom_a = ram_addr = (base+idx) mod 2^ADDR_W. ram_din = rom_d. ram_we = 1. Increment idx each cycle. After the idx=len-1 write, go to VERIFY (VERIFY_EN) or to SCAN with a done pulse.
- VERIFY: ram_we = 0. Present address base+idx each cycle for len cycles. Compare ram_dout one cycle later against rom_d, using the ROM address delayed one cycle. Any mismatch sets err. After the last compare, pulse done and go to SCAN.
- SCAN: ram_we = 0. ram_addr = disp_addr. On scan_tick, disp_addr advances to base + ((disp_addr-base+1) mod len), so the scan wraps within the block. On SCAN entry, disp_addr = base. disp_data <= ram_dout every cycle.
- start in COPY/VERIFY is ignored (no queueing). scan_tick outside SCAN is ignored.
- base and len are sampled on start and held internally. Later changes to the inputs have no effect until the next start.
- Address arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W. A block crossing the top address wraps to 0.

## Timing
- Copy of N words: busy for N cycles. Writes happen on cycles 1..N after start.
- Verify: N+1 cycles (1-cycle read pipeline). done is asserted on the cycle after the last compare. err is valid in the same cycle as done.
- Total start→done latency: N+1 without verify, 2N+2 with VERIFY_EN.
- disp_data reflects a new disp_addr 2 cycles after the scan_tick (address register + RAM read).
- start in the same cycle as done is accepted, because the FSM is already in SCAN.
- rst in mid-copy aborts immediately. The RAM contents are whatever was already written. There is no done pulse.

## Configuration
- MEMSEQ_VERIFY_EN defined: the VERIFY state, compare pipeline and err register are built.
- MEMSEQ_VERIFY_EN undefined: COPY goes directly to SCAN and err is tied to 0. Latency is N+1.

## Structure
- Shared package mem_seq_pkg holds:
  - the state enum (IDLE, COPY, VERIFY, SCAN)
  - the ADDR_W/DATA_W defaults
- No sub-module is needed, except one natural one: mem_seq_cmp. It is the 1-cycle delayed compare stage (delayed expected data, valid flag, sticky err). It is instantiated only under MEMSEQ_VERIFY_EN.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, state IDLE, no ram_we.
- ROM word[a]=a*3, base=8, len=4, start → ram_we on 4 consecutive cycles at addresses 8..11 with data 24,27,30,33. done pulses at cycle 5 (no verify) or cycle 10 (verify). err=0.
- Verify mismatch: force ram_dout at address 10 to 0xDEADBEEF → err=1 at done, and err stays 1 until the next start.
- Wrap: base=1022, len=4 → writes to addresses 1022, 1023, 0, 1. In SCAN, 5 scan_ticks → disp_addr sequence 1022, 1023, 0, 1, 1022, 1023.
- start during COPY, and len=0 start → the in-progress copy is unaffected. len=0 gives done one cycle later with no ram_we.
- rst asserted at the 2nd copy write → the next cycle shows state IDLE, all outputs 0, and no done pulse.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the memory sequencer (mem_seq_ctrl and mem_seq_cmp).
package mem_seq_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COPY   = 2'd1,
        S_VERIFY = 2'd2,
        S_SCAN   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_seq_cmp.sv
// Read-back compare stage: holds the expected ROM word for one cycle so it lines up
// with the RAM read data, and keeps a sticky mismatch flag.
module mem_seq_cmp #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              vld,
    input  logic [DATA_W-1:0] exp_d,
    input  logic [DATA_W-1:0] act_d,
    output logic              err
);

    logic              vld_p1;
    logic [DATA_W-1:0] exp_p1;

    // control: valid flag and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            err    <= 1'b0;
        end else begin
            vld_p1 <= vld;
            if (clr) begin
                err <= 1'b0;
            end else if (vld_p1 && (act_d != exp_p1)) begin
                err <= 1'b1;
            end
        end
    end

    // data: expected word delayed to match the RAM read latency
    always_ff @(posedge clk) begin
        exp_p1 <= exp_d;
    end

endmodule

// File: rtl/mem_seq_ctrl.sv
// ROM-to-RAM block copier with optional read-back verify and a display scan over the block.
// Define MEMSEQ_VERIFY_EN to build the VERIFY state, compare stage and err flag.
module mem_seq_ctrl
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              scan_tick,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [DATA_W-1:0] rom_d,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] disp_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] scan_off;
    logic [ADDR_W-1:0] scan_nxt;
    logic [ADDR_W-1:0] next_addr;
    logic              accept;

    // Offset within the block wraps at len, so the scan never leaves the copied words.
    always_comb begin
        scan_nxt = scan_off + ADDR_ONE;
        if (scan_off == (len_r - ADDR_ONE)) begin
            scan_nxt = '0;
        end
    end

    assign next_addr = base_r + idx + ADDR_ONE;
    assign accept    = start && ((state == S_IDLE) || (state == S_SCAN));

    // ROM data flows straight into the RAM; gated so the port reads 0 when not writing.
    assign ram_din = ram_we ? rom_d : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            base_r    <= '0;
            len_r     <= '0;
            scan_off  <= '0;
            rom_a     <= '0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            disp_data <= '0;
            disp_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_SCAN: begin
                    if (state == S_SCAN) begin
                        disp_data <= ram_dout;
                        if (scan_tick && (len_r != '0)) begin
                            scan_off  <= scan_nxt;
                            disp_addr <= base_r + scan_nxt;
                            ram_addr  <= base_r + scan_nxt;
                        end
                    end
                    if (start) begin
                        base_r <= base;
                        len_r  <= len;
                        idx    <= '0;
                        if (len == '0) begin
                            state     <= S_SCAN;
                            done      <= 1'b1;
                            scan_off  <= '0;
                            disp_addr <= base;
                            ram_addr  <= base;
                        end else begin
                            state    <= S_COPY;
                            busy     <= 1'b1;
                            rom_a    <= base;
                            ram_addr <= base;
                            ram_we   <= 1'b1;
                        end
                    end
                end
                S_COPY: begin
                    if (idx == (len_r - ADDR_ONE)) begin
                        ram_we <= 1'b0;
`ifdef MEMSEQ_VERIFY_EN
                        state    <= S_VERIFY;
                        idx      <= '0;
                        rom_a    <= base_r;
                        ram_addr <= base_r;
`else
                        state     <= S_SCAN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        scan_off  <= '0;
                        disp_addr <= base_r;
                        ram_addr  <= base_r;
`endif
                    end else begin
                        idx      <= idx + ADDR_ONE;
                        rom_a    <= next_addr;
                        ram_addr <= next_addr;
                    end
                end
`ifdef MEMSEQ_VERIFY_EN
                S_VERIFY: begin
                    // idx == len is the drain cycle for the last read in flight.
                    if (idx == len_r) begin
                        state     <= S_SCAN;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        scan_off  <= '0;
                        disp_addr <= base_r;
                        ram_addr  <= base_r;
                    end else begin
                        idx      <= idx + ADDR_ONE;
                        rom_a    <= next_addr;
                        ram_addr <= next_addr;
                    end
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MEMSEQ_VERIFY_EN
    logic cmp_vld;

    assign cmp_vld = (state == S_VERIFY) && (idx != len_r);

    mem_seq_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk   (clk),
        .rst   (rst),
        .clr   (accept),
        .vld   (cmp_vld),
        .exp_d (rom_d),
        .act_d (ram_dout),
        .err   (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule
